// File: rtl/vec_wb_packer.sv
// Vector write-back packer.
// Collects lane-serial result elements, merges them over the current
// register-group contents (mask- and tail-undisturbed) and issues one
// group-wide write to the vector register file.
module vec_wb_packer #(
  parameter int VLEN       = 512,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8*VLEN,
  parameter int ELEM_W     = 32,
  parameter int VL_WIDTH   = $clog2(DATA_WIDTH/8)+1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_waddr,
  input  logic [3:0]            cfg_lmul,
  input  logic [1:0]            cfg_sew,
  input  logic [VL_WIDTH-1:0]   cfg_vl,
  input  logic                  cfg_vm,
  input  logic                  flush,
  input  logic                  elem_valid,
  input  logic [ELEM_W-1:0]     elem_data,
  output logic                  elem_ready,
  input  logic [DATA_WIDTH-1:0] dst_data,
  input  logic [VLEN-1:0]       v0_mask_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [3:0]            lmul,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_error
);

  localparam int NBYTES = DATA_WIDTH/8;
  localparam int MIDX_W = $clog2(VLEN);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_COLLECT = 2'd2;
  localparam logic [1:0] S_WRITE   = 2'd3;

  logic [1:0]            state_reg, state_next;
  logic [1:0]            sew_reg;
  logic [VL_WIDTH-1:0]   vl_reg;
  logic [VL_WIDTH-1:0]   cnt_reg;
  logic                  vm_reg;
  logic [ADDR_WIDTH-1:0] waddr_reg;
  logic [3:0]            lmul_reg;
  logic                  cfg_error_reg;
  logic [DATA_WIDTH-1:0] buffer;

  logic                  lmul_onehot, addr_aligned, sew_ok, vl_ok, mask_ok, cfg_legal;
  logic [VL_WIDTH:0]     max_elems;
  logic                  accept_start, accept, last_elem, elem_en, load_en;

  // Legality of the requested configuration; the element limit is the
  // group size in bytes scaled down by the element width.
  always_comb begin
    lmul_onehot  = 1'b0;
    addr_aligned = 1'b0;
    max_elems    = '0;
    case (cfg_lmul)
      4'b0001: begin
        lmul_onehot  = 1'b1;
        addr_aligned = 1'b1;
        max_elems    = (VL_WIDTH+1)'(VLEN/8);
      end
      4'b0010: begin
        lmul_onehot  = 1'b1;
        addr_aligned = (cfg_waddr[0] == 1'b0);
        max_elems    = (VL_WIDTH+1)'(VLEN/4);
      end
      4'b0100: begin
        lmul_onehot  = 1'b1;
        addr_aligned = (cfg_waddr[1:0] == 2'b00);
        max_elems    = (VL_WIDTH+1)'(VLEN/2);
      end
      4'b1000: begin
        lmul_onehot  = 1'b1;
        addr_aligned = (cfg_waddr[2:0] == 3'b000);
        max_elems    = (VL_WIDTH+1)'(VLEN);
      end
      default: ;
    endcase
    max_elems = max_elems >> cfg_sew;
    sew_ok    = (cfg_sew != 2'b11);
    vl_ok     = ({1'b0, cfg_vl} <= max_elems);
    // A masked write must never target v0, which holds the mask itself.
    mask_ok   = cfg_vm | (cfg_waddr != '0);
    cfg_legal = lmul_onehot & addr_aligned & sew_ok & vl_ok & mask_ok;
  end

  assign accept_start = (state_reg == S_IDLE) & start;
  // flush wins over a same-cycle element so an aborted group is never touched.
  assign accept       = (state_reg == S_COLLECT) & elem_valid & ~flush;
  assign last_elem    = ((cnt_reg + VL_WIDTH'(1)) == vl_reg);
  assign elem_en      = accept & (vm_reg | v0_mask_data[cnt_reg[MIDX_W-1:0]]);
  assign load_en      = (state_reg == S_LOAD) & ~flush;

  // Next-state selection for the IDLE/LOAD/COLLECT/WRITE sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (start && cfg_legal) state_next = S_LOAD;
      S_LOAD: begin
        if (flush)                state_next = S_IDLE;
        else if (vl_reg != '0)    state_next = S_COLLECT;
        else                      state_next = S_WRITE;
      end
      S_COLLECT: begin
        if (flush)                       state_next = S_IDLE;
        else if (accept && last_elem)    state_next = S_WRITE;
      end
      S_WRITE:   state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Control state, configuration latches and the element counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      sew_reg       <= '0;
      vl_reg        <= '0;
      vm_reg        <= 1'b0;
      waddr_reg     <= '0;
      lmul_reg      <= '0;
      cfg_error_reg <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      cfg_error_reg <= accept_start & ~cfg_legal;
      if (accept_start && cfg_legal) begin
        sew_reg   <= cfg_sew;
        vl_reg    <= cfg_vl;
        vm_reg    <= cfg_vm;
        waddr_reg <= cfg_waddr;
        lmul_reg  <= cfg_lmul;
      end
      if (state_reg == S_LOAD)
        cnt_reg <= '0;
      else if (accept)
        cnt_reg <= cnt_reg + VL_WIDTH'(1);
    end
  end

  // One merge-buffer byte per lane: loaded from the group, then overwritten
  // by whichever element (for the latched SEW) covers this byte.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_byte
      logic       hit;
      logic [7:0] byte_val;
      logic [7:0] byte_reg;

      // Decode whether the current element index owns this byte.
      always_comb begin
        hit      = 1'b0;
        byte_val = elem_data[7:0];
        case (sew_reg)
          2'b00: begin
            hit      = (cnt_reg == VL_WIDTH'(gi));
            byte_val = elem_data[7:0];
          end
          2'b01: begin
            hit      = (cnt_reg == VL_WIDTH'(gi/2));
            byte_val = elem_data[(gi%2)*8 +: 8];
          end
          2'b10: begin
            hit      = (cnt_reg == VL_WIDTH'(gi/4));
            byte_val = elem_data[(gi%4)*8 +: 8];
          end
          default: ;
        endcase
      end

      // Byte storage: group load first, then enabled element writes.
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          byte_reg <= '0;
        else if (load_en)
          byte_reg <= dst_data[gi*8 +: 8];
        else if (elem_en && hit)
          byte_reg <= byte_val;
      end

      assign buffer[gi*8 +: 8] = byte_reg;
    end
  endgenerate

  assign elem_ready = (state_reg == S_COLLECT);
  assign wr_en      = (state_reg == S_WRITE);
  assign done       = (state_reg == S_WRITE);
  assign busy       = (state_reg != S_IDLE);
  assign cfg_error  = cfg_error_reg;
  assign waddr      = waddr_reg;
  assign lmul       = lmul_reg;
  assign wdata      = buffer;

endmodule

// File: tb/tb_vec_wb_packer.sv
// Self-checking bench for vec_wb_packer: randomized groups, masks and
// element gaps checked against an element-level merge model.
module tb_vec_wb_packer;

  localparam int VLEN = 512;
  localparam int AW   = 5;
  localparam int DW   = 8*VLEN;
  localparam int EW   = 32;
  localparam int VLW  = $clog2(DW/8)+1;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [AW-1:0]  cfg_waddr;
  logic [3:0]     cfg_lmul;
  logic [1:0]     cfg_sew;
  logic [VLW-1:0] cfg_vl;
  logic           cfg_vm;
  logic           flush;
  logic           elem_valid;
  logic [EW-1:0]  elem_data;
  logic           elem_ready;
  logic [DW-1:0]  dst_data;
  logic [VLEN-1:0] v0_mask_data;
  logic           wr_en;
  logic [AW-1:0]  waddr;
  logic [3:0]     lmul;
  logic [DW-1:0]  wdata;
  logic           busy;
  logic           done;
  logic           cfg_error;

  vec_wb_packer dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_waddr(cfg_waddr), .cfg_lmul(cfg_lmul), .cfg_sew(cfg_sew),
    .cfg_vl(cfg_vl), .cfg_vm(cfg_vm), .flush(flush),
    .elem_valid(elem_valid), .elem_data(elem_data), .elem_ready(elem_ready),
    .dst_data(dst_data), .v0_mask_data(v0_mask_data),
    .wr_en(wr_en), .waddr(waddr), .lmul(lmul), .wdata(wdata),
    .busy(busy), .done(done), .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] elems [512];
  int  op_vl, op_sewb;
  bit  op_vm;

  int  wr_count, wr_cycle, err_count, busy_seen, ready_seen, done_bad, timeout, busy_after_flush;
  logic [DW-1:0] wdata_cap;
  logic [AW-1:0] waddr_cap;
  logic [3:0]    lmul_cap;

  function automatic logic [31:0] sew_mask();
    if (op_sewb == 32) return 32'hFFFF_FFFF;
    return (32'h1 << op_sewb) - 32'h1;
  endfunction

  // Expected group image after the first n elements were accepted.
  function automatic logic [DW-1:0] model(input int n);
    logic [DW-1:0] r;
    r = dst_data;
    for (int i = 0; i < n; i++)
      if (op_vm || v0_mask_data[i])
        for (int b = 0; b < op_sewb; b++)
          r[i*op_sewb + b] = elems[i][b];
    return r;
  endfunction

  task automatic rand_dst();
    for (int w = 0; w < DW/32; w++) dst_data[w*32 +: 32] = $urandom();
  endtask

  task automatic rand_v0();
    for (int w = 0; w < VLEN/32; w++) v0_mask_data[w*32 +: 32] = $urandom();
  endtask

  task automatic set_cfg(input int wa, input logic [3:0] lm, input logic [1:0] sw, input int vl, input bit vm);
    cfg_waddr = AW'(wa);
    cfg_lmul  = lm;
    cfg_sew   = sw;
    cfg_vl    = VLW'(vl);
    cfg_vm    = vm;
    op_vl     = vl;
    op_vm     = vm;
    op_sewb   = (sw == 2'b00) ? 8 : (sw == 2'b01) ? 16 : 32;
  endtask

  task automatic fill_elems();
    for (int i = 0; i < 512; i++) elems[i] = $urandom() & sew_mask();
  endtask

  // Pulse start, then act as the element producer cycle by cycle until
  // the packer returns to idle, recording what the register file would see.
  task automatic run_op(input int gap_pct, input int flush_at);
    int idx;
    bit acc;
    bit fl;
    idx = 0;
    wr_count = 0; wr_cycle = -1; err_count = 0; busy_seen = 0; ready_seen = 0;
    done_bad = 0; timeout = 1; busy_after_flush = -1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc < 4000; cyc++) begin
      fl = (flush_at >= 0) && (idx == flush_at) && (busy_after_flush < 0);
      flush = fl;
      if (!fl && idx < op_vl && $urandom_range(99) >= gap_pct) begin
        elem_valid = 1'b1;
        elem_data  = ($urandom() & ~sew_mask()) | elems[idx];
      end else begin
        elem_valid = 1'b0;
        elem_data  = $urandom();
      end
      @(negedge clk);
      if (busy) busy_seen++;
      if (elem_ready) ready_seen++;
      if (cfg_error) err_count++;
      if (wr_en) begin
        wr_count++;
        wr_cycle  = cyc;
        wdata_cap = wdata;
        waddr_cap = waddr;
        lmul_cap  = lmul;
      end
      if (wr_en !== done) done_bad++;
      acc = elem_ready && elem_valid;
      @(posedge clk); #1;
      if (acc) idx++;
      if (fl) busy_after_flush = int'(busy);
      if (cyc >= 3 && !busy) begin
        timeout = 0;
        break;
      end
    end
    flush = 1'b0;
    elem_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    vectors++;
    if ({wr_en, done, busy, elem_ready, cfg_error} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b expected 00000", {wr_en, done, busy, elem_ready, cfg_error});
    end
    vectors++;
    if (waddr !== '0 || lmul !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_addr: got waddr=%0d lmul=%b expected 0/0000", waddr, lmul);
    end
    vectors++;
    if (wdata !== '0) begin
      miscompares++;
      $display("FAIL reset_wdata: got low=%h expected 0", wdata[63:0]);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got busy=%b wr_en=%b expected 0/0", busy, wr_en);
    end
    $display("test_reset done");
  endtask

  task automatic test_unmasked_sew8();
    rand_dst(); rand_v0();
    set_cfg(4, 4'b0001, 2'b00, 4, 1'b1);
    fill_elems();
    elems[0] = 32'h11; elems[1] = 32'h22; elems[2] = 32'h33; elems[3] = 32'h44;
    run_op(0, -1);
    vectors++;
    if (timeout != 0 || wr_count != 1 || wr_cycle != 6) begin
      miscompares++;
      $display("FAIL sew8_timing: got writes=%0d cycle=%0d timeout=%0d expected 1/6/0", wr_count, wr_cycle, timeout);
    end
    vectors++;
    if (wdata_cap[31:0] !== 32'h4433_2211) begin
      miscompares++;
      $display("FAIL sew8_word0: got %h expected 44332211", wdata_cap[31:0]);
    end
    vectors++;
    if (wdata_cap[511:32] !== dst_data[511:32] || wdata_cap !== model(op_vl)) begin
      miscompares++;
      $display("FAIL sew8_tail: got low=%h expected low=%h", wdata_cap[63:0], dst_data[63:0]);
    end
    vectors++;
    if (done_bad != 0 || waddr_cap !== 5'd4 || lmul_cap !== 4'b0001) begin
      miscompares++;
      $display("FAIL sew8_outputs: got done_bad=%0d waddr=%0d lmul=%b expected 0/4/0001", done_bad, waddr_cap, lmul_cap);
    end
    $display("test_unmasked_sew8 writes=%0d cycle=%0d", wr_count, wr_cycle);
  endtask

  task automatic test_masked_sew32();
    rand_dst(); rand_v0();
    v0_mask_data[3:0] = 4'b0101;
    set_cfg(8, 4'b0010, 2'b10, 4, 1'b0);
    for (int i = 0; i < 512; i++) elems[i] = 32'hFFFF_FFFF;
    run_op(0, -1);
    vectors++;
    if (wr_count != 1 || wr_cycle != 6) begin
      miscompares++;
      $display("FAIL masked_timing: got writes=%0d cycle=%0d expected 1/6", wr_count, wr_cycle);
    end
    vectors++;
    if (wdata_cap[31:0] !== 32'hFFFF_FFFF || wdata_cap[95:64] !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL masked_enabled: got e0=%h e2=%h expected ffffffff", wdata_cap[31:0], wdata_cap[95:64]);
    end
    vectors++;
    if (wdata_cap[63:32] !== dst_data[63:32] || wdata_cap[127:96] !== dst_data[127:96]) begin
      miscompares++;
      $display("FAIL masked_disabled: got e1=%h e3=%h expected %h %h", wdata_cap[63:32], wdata_cap[127:96], dst_data[63:32], dst_data[127:96]);
    end
    vectors++;
    if (wdata_cap !== model(op_vl) || waddr_cap !== 5'd8 || lmul_cap !== 4'b0010) begin
      miscompares++;
      $display("FAIL masked_image: got waddr=%0d lmul=%b expected 8/0010 with model image", waddr_cap, lmul_cap);
    end
    $display("test_masked_sew32 writes=%0d cycle=%0d", wr_count, wr_cycle);
  endtask

  task automatic test_illegal();
    int          wa [5] = '{6, 0, 4, 8, 0};
    logic [3:0]  lm [5] = '{4'b0100, 4'b0001, 4'b0001, 4'b0100, 4'b0011};
    logic [1:0]  sw [5] = '{2'b00, 2'b00, 2'b11, 2'b10, 2'b00};
    int          vl [5] = '{1, 1, 1, 65, 1};
    bit          vm [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [AW-1:0] prev_waddr;
    logic [3:0]    prev_lmul;
    for (int k = 0; k < 5; k++) begin
      prev_waddr = waddr;
      prev_lmul  = lmul;
      set_cfg(wa[k], lm[k], sw[k], vl[k], vm[k]);
      fill_elems();
      run_op(0, -1);
      vectors++;
      if (err_count != 1 || busy_seen != 0 || wr_count != 0) begin
        miscompares++;
        $display("FAIL illegal_%0d: got err=%0d busy=%0d writes=%0d expected 1/0/0", k, err_count, busy_seen, wr_count);
      end
      vectors++;
      if (waddr !== prev_waddr || lmul !== prev_lmul) begin
        miscompares++;
        $display("FAIL illegal_hold_%0d: got waddr=%0d lmul=%b expected %0d/%b", k, waddr, lmul, prev_waddr, prev_lmul);
      end
      $display("test_illegal case %0d err_pulses=%0d", k, err_count);
    end
  endtask

  task automatic test_vl_max();
    rand_dst(); rand_v0();
    set_cfg(8, 4'b0100, 2'b10, 64, 1'b1);
    fill_elems();
    run_op(0, -1);
    vectors++;
    if (err_count != 0 || wr_count != 1 || wr_cycle != 66 || wdata_cap !== model(op_vl)) begin
      miscompares++;
      $display("FAIL vl_max: got err=%0d writes=%0d cycle=%0d expected 0/1/66 with model image", err_count, wr_count, wr_cycle);
    end
    $display("test_vl_max writes=%0d cycle=%0d", wr_count, wr_cycle);
  endtask

  task automatic test_vl0();
    rand_dst(); rand_v0();
    set_cfg(16, 4'b1000, 2'b00, 0, 1'b1);
    fill_elems();
    run_op(0, -1);
    vectors++;
    if (wr_count != 1 || wr_cycle != 2 || ready_seen != 0) begin
      miscompares++;
      $display("FAIL vl0_timing: got writes=%0d cycle=%0d ready=%0d expected 1/2/0", wr_count, wr_cycle, ready_seen);
    end
    vectors++;
    if (wdata_cap !== dst_data || waddr_cap !== 5'd16 || lmul_cap !== 4'b1000) begin
      miscompares++;
      $display("FAIL vl0_image: got low=%h waddr=%0d expected low=%h waddr=16", wdata_cap[63:0], waddr_cap, dst_data[63:0]);
    end
    $display("test_vl0 writes=%0d cycle=%0d", wr_count, wr_cycle);
  endtask

  task automatic test_gaps_and_flush();
    rand_dst(); rand_v0();
    set_cfg(24, 4'b1000, 2'b00, 512, 1'b1);
    fill_elems();
    run_op(30, -1);
    vectors++;
    if (timeout != 0 || wr_count != 1 || wdata_cap !== model(op_vl)) begin
      miscompares++;
      $display("FAIL gaps_full: got writes=%0d timeout=%0d low=%h expected 1/0 low=%h", wr_count, timeout, wdata_cap[63:0], model(op_vl) & 64'hFFFF_FFFF_FFFF_FFFF);
    end
    $display("test_gaps writes=%0d cycle=%0d", wr_count, wr_cycle);
    rand_dst();
    fill_elems();
    run_op(30, 100);
    vectors++;
    if (timeout != 0 || wr_count != 0 || busy_after_flush != 0) begin
      miscompares++;
      $display("FAIL flush: got writes=%0d busy_next=%0d timeout=%0d expected 0/0/0", wr_count, busy_after_flush, timeout);
    end
    vectors++;
    if (wdata !== model(100)) begin
      miscompares++;
      $display("FAIL flush_retained: got low=%h expected first 100 elements merged", wdata[63:0]);
    end
    $display("test_flush writes=%0d busy_next=%0d", wr_count, busy_after_flush);
  endtask

  task automatic test_back_to_back();
    int k, n, sw, maxv, vl, wa, gap;
    bit vm;
    for (int t = 0; t < 8; t++) begin
      k  = $urandom_range(3);
      n  = 1 << k;
      sw = $urandom_range(2);
      maxv = n * VLEN / (8 << sw);
      vl = $urandom_range(maxv);
      vm = $urandom_range(1);
      wa = n * $urandom_range(32/n - 1);
      if (!vm && wa == 0) wa = n;
      gap = (t % 2 == 0) ? 0 : 20;
      rand_dst(); rand_v0();
      set_cfg(wa, 4'(n), 2'(sw), vl, vm);
      fill_elems();
      run_op(gap, -1);
      vectors++;
      if (timeout != 0 || wr_count != 1 || wdata_cap !== model(op_vl) || waddr_cap !== AW'(wa) || lmul_cap !== 4'(n)) begin
        miscompares++;
        $display("FAIL b2b_%0d: got writes=%0d waddr=%0d lmul=%b low=%h expected 1/%0d/%b low=%h", t, wr_count, waddr_cap, lmul_cap, wdata_cap[63:0], wa, 4'(n), model(op_vl) & 64'hFFFF_FFFF_FFFF_FFFF);
      end
      if (gap == 0) begin
        vectors++;
        if (wr_cycle != vl + 2) begin
          miscompares++;
          $display("FAIL b2b_latency_%0d: got cycle=%0d expected %0d", t, wr_cycle, vl + 2);
        end
      end
      $display("test_back_to_back op %0d lmul=%0d sew=%0d vl=%0d vm=%0d writes=%0d cycle=%0d", t, n, sw, vl, vm, wr_count, wr_cycle);
    end
  endtask

  task automatic test_reset_mid();
    int wr_seen;
    rand_dst(); rand_v0();
    set_cfg(12, 4'b0100, 2'b01, 20, 1'b1);
    fill_elems();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    elem_valid = 1'b1;
    elem_data  = elems[0];
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    vectors++;
    if ({wr_en, done, busy, elem_ready, cfg_error} !== 5'b0 || waddr !== '0 || lmul !== 4'b0 || wdata !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got strobes=%b waddr=%0d lmul=%b low=%h expected all zero", {wr_en, done, busy, elem_ready, cfg_error}, waddr, lmul, wdata[63:0]);
    end
    @(negedge clk);
    reset = 1'b0;
    elem_valid = 1'b0;
    wr_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (wr_en) wr_seen++;
    end
    vectors++;
    if (wr_seen != 0) begin
      miscompares++;
      $display("FAIL reset_mid_nowrite: got writes=%0d expected 0", wr_seen);
    end
    run_op(0, -1);
    vectors++;
    if (wr_count != 1 || wr_cycle != 22 || wdata_cap !== model(op_vl)) begin
      miscompares++;
      $display("FAIL reset_mid_restart: got writes=%0d cycle=%0d expected 1/22 with model image", wr_count, wr_cycle);
    end
    $display("test_reset_mid restart writes=%0d cycle=%0d", wr_count, wr_cycle);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b0; flush = 1'b0; elem_valid = 1'b0; elem_data = '0;
    cfg_waddr = '0; cfg_lmul = '0; cfg_sew = '0; cfg_vl = '0; cfg_vm = 1'b1;
    dst_data = '0; v0_mask_data = '0;
    op_vl = 0; op_sewb = 8; op_vm = 1'b1;
    test_reset();
    test_unmasked_sew8();
    test_masked_sew32();
    test_illegal();
    test_vl_max();
    test_vl0();
    test_gaps_and_flush();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
